// File: rtl/ff_seq_pkg.sv
// Shared types and constants for the RC flip-flop bank write sequencer.
// Window lengths are held in a 4-bit down-counter.
package ff_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    FIN
  } state_t;

  localparam int CNT_W   = 4;
  localparam int CYC_MIN = 1;
  localparam int CYC_MAX = 15;

  function automatic bit cyc_ok(input int c);
    return (c >= CYC_MIN) && (c <= CYC_MAX);
  endfunction

endpackage

// File: rtl/seq_cnt.sv
// Loadable down-counter with zero flag.
// Shared by the setup, pulse and hold windows.
import ff_seq_pkg::*;

module seq_cnt (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ff8_loader.sv
// Write-side sequencer for the 8-bit RC flip-flop bank:
// presents a byte, pulses the capture clock pair, checks readback.
import ff_seq_pkg::*;

module ff8_loader #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter bit CHECK_EN  = 1'b1
) (
  input  logic             CK,
  input  logic             RSTB,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] D_OUT,
  output logic             CAP_CK,
  output logic             CAP_CKB,
  input  logic [WIDTH-1:0] Q_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  if (!(cyc_ok(SETUP_CYC) && cyc_ok(PULSE_CYC)
        && cyc_ok(HOLD_CYC))) begin : g_bad_cyc
    $error("ff8_loader: window length outside 1..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_dout;
  logic             r_cap;
  logic             r_capb;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_accept;
  logic             w_zero;
  logic             w_load;
  logic [CNT_W-1:0] w_ld_val;
  logic             w_dec;
  logic             w_set_end;
  logic             w_pls_end;
  logic             w_hld_end;

  assign IN_READY  = RSTB && ((r_state == IDLE) || (r_state == FIN));
  assign w_accept  = IN_VALID && IN_READY;
  assign w_set_end = (r_state == SETUP) && w_zero;
  assign w_pls_end = (r_state == PULSE) && w_zero;
  assign w_hld_end = (r_state == HOLD) && w_zero;

  always_comb begin
    w_load   = 1'b0;
    w_ld_val = '0;
    w_dec    = 1'b0;
    unique case (1'b1)
      w_accept: begin
        w_load   = 1'b1;
        w_ld_val = SETUP_LD;
      end
      w_set_end: begin
        w_load   = 1'b1;
        w_ld_val = PULSE_LD;
      end
      w_pls_end: begin
        w_load   = 1'b1;
        w_ld_val = HOLD_LD;
      end
      default: w_dec = 1'b1;
    endcase
  end

  seq_cnt u_cnt (
    .i_clk   (CK),
    .i_rst_n (RSTB),
    .i_load  (w_load),
    .i_val   (w_ld_val),
    .i_dec   (w_dec),
    .o_zero  (w_zero)
  );

  // CAP_CK and CAP_CKB are separate flops updated together, never equal
  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= IDLE;
      r_dout  <= '0;
      r_cap   <= 1'b0;
      r_capb  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_dout  <= IN_DATA;
            r_state <= SETUP;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SETUP: begin
          if (w_zero) begin
            r_state <= PULSE;
            r_cap   <= 1'b1;
            r_capb  <= 1'b0;
          end
        end
        PULSE: begin
          if (w_zero) begin
            r_state <= HOLD;
            r_cap   <= 1'b0;
            r_capb  <= 1'b1;
          end
        end
        HOLD: begin
          if (w_zero) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= CHECK_EN && (Q_IN != r_dout);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign D_OUT   = r_dout;
  assign CAP_CK  = r_cap;
  assign CAP_CKB = r_capb;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;

endmodule

// File: tb/tb_ff8_loader.sv
// Directed bench for ff8_loader: default timing instance
// plus a stretched-window instance (3/2/4).
module tb_ff8_loader;

  logic       clk;
  logic       rstb;

  logic       iv;
  logic       ird;
  logic [7:0] idat;
  logic [7:0] dout;
  logic       cap;
  logic       capb;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       err;
  logic       flt;
  logic [7:0] fq;

  logic       sv;
  logic       srd;
  logic [7:0] sdat;
  logic [7:0] sdout;
  logic       scap;
  logic       scapb;
  logic       sbusy;
  logic       sdone;
  logic       serr;

  int nchk;
  int nerr;

  assign q = flt ? fq : dout;

  ff8_loader u_dut (
    .CK       (clk),
    .RSTB     (rstb),
    .IN_VALID (iv),
    .IN_READY (ird),
    .IN_DATA  (idat),
    .D_OUT    (dout),
    .CAP_CK   (cap),
    .CAP_CKB  (capb),
    .Q_IN     (q),
    .BUSY     (busy),
    .DONE     (done),
    .ERR      (err)
  );

  ff8_loader #(
    .SETUP_CYC (3),
    .PULSE_CYC (2),
    .HOLD_CYC  (4)
  ) u_swp (
    .CK       (clk),
    .RSTB     (rstb),
    .IN_VALID (sv),
    .IN_READY (srd),
    .IN_DATA  (sdat),
    .D_OUT    (sdout),
    .CAP_CK   (scap),
    .CAP_CKB  (scapb),
    .Q_IN     (sdout),
    .BUSY     (sbusy),
    .DONE     (sdone),
    .ERR      (serr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       flt;
    logic [7:0] fq;
    logic       exp_err;
  } vec_t;

  vec_t tbl[6];

  // one write on the default instance, accept at edge 0
  task automatic write_one(input vec_t v);
    @(negedge clk);
    flt  = v.flt;
    fq   = v.fq;
    iv   = 1'b1;
    idat = v.data;
    chk("ready_idle", ird, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) iv = 1'b0;
      chk("dout", dout, v.data);
      chk("cap", cap, (k == 2));
      chk("capb", capb, (k != 2));
      chk("done", done, (k == 4));
      chk("busy", busy, (k < 4));
      if (k >= 4) chk("err", err, v.exp_err);
    end
    flt = 1'b0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rstb = 1'b1;
    iv   = 1'b1;
    idat = 8'h77;
    flt  = 1'b0;
    fq   = 8'h00;
    sv   = 1'b0;
    sdat = 8'h00;

    tbl[0] = '{8'hA5, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 8'hA4, 1'b1};
    tbl[2] = '{8'h3C, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 8'h7F, 1'b1};
    tbl[5] = '{8'h5A, 1'b0, 8'h00, 1'b0};

    // reset held with IN_VALID high
    #2 rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_cap", cap, 0);
    chk("rst_capb", capb, 1);
    chk("rst_ready", ird, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    iv   = 1'b0;
    rstb = 1'b1;
    @(negedge clk);
    chk("rel_ready", ird, 1);
    chk("rel_dout", dout, 8'h00);

    for (int i = 0; i < 6; i++) write_one(tbl[i]);

    // back-to-back: accepts at edges 0, 5, 10
    @(negedge clk);
    iv   = 1'b1;
    idat = 8'h01;
    for (int e = 0; e < 15; e++) begin
      @(negedge clk);
      chk("b2b_pair", cap ^ capb, 1);
      chk("b2b_done", done, (e % 5 == 4));
      chk("b2b_ready", ird, (e % 5 == 4));
      chk("b2b_dout", dout,
          (e < 5) ? 8'h01 : (e < 10) ? 8'h02 : 8'h03);
      if (e == 0) idat = 8'h02;
      if (e == 5) idat = 8'h03;
      if (e == 10) iv = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle", ird, 1);
    chk("b2b_err", err, 0);

    // reset while the capture pulse is high
    @(negedge clk);
    iv   = 1'b1;
    idat = 8'hC3;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      if (e == 0) iv = 1'b0;
    end
    chk("mid_cap_pre", cap, 1);
    #2 rstb = 1'b0;
    #1;
    chk("mid_cap", cap, 0);
    chk("mid_capb", capb, 1);
    chk("mid_dout", dout, 8'h00);
    chk("mid_ready", ird, 0);
    @(negedge clk);
    rstb = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      chk("mid_nodone", done, 0);
      chk("mid_cap_low", cap, 0);
    end
    write_one(tbl[2]);

    // stretched windows: 3/2/4, second accept at edge 10
    @(negedge clk);
    sv   = 1'b1;
    sdat = 8'hFF;
    for (int e = 0; e < 11; e++) begin
      @(negedge clk);
      if (e == 0) sdat = 8'h5A;
      chk("swp_cap", scap, (e == 3 || e == 4));
      chk("swp_capb", scapb, !(e == 3 || e == 4));
      chk("swp_done", sdone, (e == 9));
      chk("swp_dout", sdout, (e < 10) ? 8'hFF : 8'h5A);
      if (e == 9) chk("swp_err", serr, 0);
      if (e == 10) sv = 1'b0;
    end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("swp_done2", sdone, (j == 8));
    end
    chk("swp_ready", srd, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
